// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_pkg
//  Description : Shared CPU constants and types for the iterative
//                multiply/divide unit (ALU codes, FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0100;

    // Counter value seen during the 32nd CALC iteration
    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration: shift-add multiply step or
//                restoring shift-subtract divide step on {acc_hi, acc_lo}.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_unit_pkg::*;
(
    input  muldiv_op_t  i_op,
    input  logic [31:0] i_acc_hi,
    input  logic [31:0] i_acc_lo,
    input  logic [31:0] i_operand,
    output logic [31:0] o_next_hi,
    output logic [31:0] o_next_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_rem_shift;
    logic [31:0] w_diff;
    logic        w_fits;

    // Multiply: acc_lo holds the multiplier, consumed LSB first
    assign w_sum = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_operand} : 33'd0);

    // Divide: remainder stays below the divisor, so the shifted value needs
    // 33 bits and a successful subtraction always fits back into 32.
    assign w_rem_shift = {i_acc_hi, i_acc_lo[31]};
    assign w_fits      = (w_rem_shift >= {1'b0, i_operand});
    assign w_diff      = w_rem_shift[31:0] - i_operand;

    always_comb begin
        o_next_hi = i_acc_hi;
        o_next_lo = i_acc_lo;
        if (i_op == OP_MUL) begin
            o_next_hi = w_sum[32:1];
            o_next_lo = {w_sum[0], i_acc_lo[31:1]};
        end else begin
            o_next_hi = w_fits ? w_diff : w_rem_shift[31:0];
            o_next_lo = {i_acc_lo[30:0], w_fits};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32-bit signed/unsigned multiply and divide unit
//                with HI/LO result registers (33-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  alu_op,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t r_state;
    muldiv_state_t w_next_state;
    muldiv_op_t    r_op;
    logic [5:0]    r_count;
    logic          r_is_signed;
    logic          r_a_sign;
    logic          r_b_sign;
    logic [31:0]   r_a_mag;
    logic [31:0]   r_b_mag;
    logic [31:0]   r_acc_hi;
    logic [31:0]   r_acc_lo;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_done;

    logic          w_start_ok;
    logic          w_load;
    logic          w_step;
    logic          w_fix;
    logic          w_load_div;
    logic [31:0]   w_a_mag_in;
    logic [31:0]   w_b_mag_in;
    logic [31:0]   w_operand;
    logic [31:0]   w_step_hi;
    logic [31:0]   w_step_lo;
    logic          w_neg_q;
    logic          w_neg_r;
    logic [63:0]   w_prod;
    logic [31:0]   w_quo;
    logic [31:0]   w_rem;
    logic [31:0]   w_a_orig;
    logic [31:0]   w_res_hi;
    logic [31:0]   w_res_lo;

    assign w_start_ok = start && ((alu_op == ALU_MULT) || (alu_op == ALU_DIV));
    assign w_load_div = (alu_op == ALU_DIV);
    assign w_a_mag_in = (is_signed && a[31]) ? -a : a;
    assign w_b_mag_in = (is_signed && b[31]) ? -b : b;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_load       = 1'b1;
                    w_next_state = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_count == LAST_ITER) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                w_fix        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    assign w_operand = (r_op == OP_DIV) ? r_b_mag : r_a_mag;

    muldiv_step u_step (
        .i_op      (r_op),
        .i_acc_hi  (r_acc_hi),
        .i_acc_lo  (r_acc_lo),
        .i_operand (w_operand),
        .o_next_hi (w_step_hi),
        .o_next_lo (w_step_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= OP_MUL;
            r_count     <= 6'd0;
            r_is_signed <= 1'b0;
            r_a_sign    <= 1'b0;
            r_b_sign    <= 1'b0;
            r_a_mag     <= 32'd0;
            r_b_mag     <= 32'd0;
            r_acc_hi    <= 32'd0;
            r_acc_lo    <= 32'd0;
        end else if (w_load) begin
            r_op        <= w_load_div ? OP_DIV : OP_MUL;
            r_count     <= 6'd0;
            r_is_signed <= is_signed;
            r_a_sign    <= a[31];
            r_b_sign    <= b[31];
            r_a_mag     <= w_a_mag_in;
            r_b_mag     <= w_b_mag_in;
            r_acc_hi    <= 32'd0;
            r_acc_lo    <= w_load_div ? w_a_mag_in : w_b_mag_in;
        end else if (w_step) begin
            r_count     <= r_count + 6'd1;
            r_acc_hi    <= w_step_hi;
            r_acc_lo    <= w_step_lo;
        end
    end

    // ------------------------------------------------------ sign fix-up
    assign w_neg_q  = r_is_signed & (r_a_sign ^ r_b_sign);
    assign w_neg_r  = r_is_signed & r_a_sign;
    assign w_prod   = w_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_quo    = w_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem    = w_neg_r ? -r_acc_hi : r_acc_hi;
    assign w_a_orig = w_neg_r ? -r_a_mag : r_a_mag;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_op == OP_DIV) begin
            if (r_b_mag == 32'd0) begin
                // Divide by zero returns the dividend untouched in HI
                w_res_hi = w_a_orig;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_fix) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed vector table
//                plus hand-written reset/ignore/back-to-back sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic        is_signed = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    vec_t vecs[12];

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .alu_op    (alu_op),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Waits the 33 edges after acceptance; optionally pokes a stray start.
    task automatic wait_result(input vec_t v, input int poke_at);
        int early_done = 0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) chk({v.name, " busy"}, {63'd0, busy}, 64'd1);
            if (i < 33 && done) early_done++;
            if (i == poke_at) begin
                start = 1'b1; alu_op = ALU_MULT; is_signed = 1'b0;
                a = 32'h1234_5678; b = 32'h0000_0009;
            end
            if (i == poke_at + 1) start = 1'b0;
        end
        chk({v.name, " early done"}, 64'(early_done), 64'd0);
        chk({v.name, " done"}, {63'd0, done}, 64'd1);
        chk({v.name, " busy end"}, {63'd0, busy}, 64'd0);
        chk({v.name, " hi"}, {32'd0, hi}, {32'd0, v.hi});
        chk({v.name, " lo"}, {32'd0, lo}, {32'd0, v.lo});
    endtask

    task automatic issue(input vec_t v, input int poke_at);
        start = 1'b1; alu_op = v.op; is_signed = v.sgn; a = v.a; b = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({v.name, " done pulse"}, {63'd0, done}, 64'd0);
        wait_result(v, poke_at);
    endtask

    initial begin
        int dones;
        vecs[0]  = '{"smul -3*7",     ALU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"umul max*max",  ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{"sdiv -7/2",     ALU_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"udiv 100/7",    ALU_DIV,  1'b0, 32'd100,       32'd7,        32'd2,         32'd14};
        vecs[4]  = '{"sdiv x/0",      ALU_DIV,  1'b1, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5]  = '{"sdiv min/-1",   ALU_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        vecs[6]  = '{"umul 2^16sq",   ALU_MULT, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0};
        vecs[7]  = '{"sdiv 7/-2",     ALU_DIV,  1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        vecs[8]  = '{"sdiv -8/0",     ALU_DIV,  1'b1, 32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[9]  = '{"udiv max/16",   ALU_DIV,  1'b0, 32'hFFFF_FFFF, 32'd16,       32'd15,        32'h0FFF_FFFF};
        vecs[10] = '{"umul fffd*7",   ALU_MULT, 1'b0, 32'hFFFF_FFFD, 32'd7,        32'd6,         32'hFFFF_FFEB};
        vecs[11] = '{"smul min*min",  ALU_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi",   {32'd0, hi},   64'd0);
        chk("reset lo",   {32'd0, lo},   64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Each start lands in the previous done cycle: back-to-back issue
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i], 0);
        end

        // Unsupported ALU code is ignored
        start = 1'b1; alu_op = 4'b0101; is_signed = 1'b0; a = 32'd5; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("badop busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("badop busy2", {63'd0, busy}, 64'd0);
        chk("badop done", {63'd0, done}, 64'd0);
        chk("badop hi", {32'd0, hi}, {32'd0, vecs[11].hi});
        chk("badop lo", {32'd0, lo}, {32'd0, vecs[11].lo});

        // Stray start during CALC must not disturb the running operation
        issue(vecs[0], 5);

        // Reset 10 cycles into a divide
        start = 1'b1; alu_op = ALU_DIV; is_signed = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst hi",   {32'd0, hi},   64'd0);
        chk("rst lo",   {32'd0, lo},   64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        chk("rst no done", 64'(dones), 64'd0);

        // Explicit back-to-back pair straight out of reset recovery
        @(negedge clk);
        issue(vecs[3], 0);
        issue(vecs[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only while idle.
REQ-004 SHALL have port alu_op, input, 4 bits: ALU control code from the decoder; 4'b0011 = multiply, 4'b0100 = divide.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = mult/div (signed), 0 = multu/divu; equals ~funct[0].
REQ-006 SHALL have port a, input, 32 bits: rs operand (multiplicand/dividend).
REQ-007 SHALL have port b, input, 32 bits: rt operand (multiplier/divisor).
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo hold a new result.
REQ-010 SHALL have port hi, output, 32 bits: HI register.
REQ-011 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-013 In IDLE, start=1 with alu_op in {0011, 0100} SHALL latch operand magnitudes, operand signs, op type and is_signed, clear the iteration counter, and enter CALC.
REQ-014 In IDLE, start=1 with any other alu_op SHALL be ignored: no state change, no done.
REQ-015 start while busy=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-016 CALC SHALL perform exactly 32 iterations, one per cycle, using a 6-bit counter; after the 32nd iteration the FSM SHALL enter FIX.
REQ-017 Multiply SHALL use shift-add on unsigned magnitudes and produce a 64-bit product.
REQ-018 Divide SHALL use restoring shift-subtract on unsigned magnitudes and produce a 32-bit quotient and a 32-bit remainder.
REQ-019 FIX SHALL apply signs and write hi/lo, assert done on the following cycle, and return to IDLE in the same cycle.
REQ-020 Sign rules when is_signed=1: negate the product if sign(a)^sign(b); negate the quotient if sign(a)^sign(b); the remainder takes the sign of a.
REQ-021 Result mapping: multiply -> {hi,lo} = 64-bit product; divide -> lo = quotient, hi = remainder.
REQ-022 Divide by zero (b=0) SHALL take the normal latency and give hi = a and lo = 32'hFFFFFFFF, regardless of is_signed.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0 (32-bit wrap), with no exception.
REQ-024 Latency: if start is accepted at edge k, hi/lo SHALL update at edge k+33 and done SHALL be high for exactly one cycle after edge k+33; busy SHALL be high from edge k+1 through edge k+33.
REQ-025 hi/lo SHALL hold their value at all times except the FIX write.
REQ-026 A start presented in the done cycle (state IDLE) SHALL be accepted, giving back-to-back operation with no gap.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and counter=0, including mid-operation; the in-flight result SHALL be discarded.
REQ-028 The first start after rst deasserts SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-029 The shared CPU package SHALL hold ALU_MULT=4'b0011, ALU_DIV=4'b0100, and the state encoding IDLE/CALC/FIX.
REQ-030 One combinational sub-module, muldiv_step, SHALL compute a single add-or-subtract iteration; muldiv_unit SHALL hold all registers and the FSM.

Verification
REQ-031 Signed multiply a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, with done exactly 34 cycles after the start edge.
REQ-032 Unsigned multiply a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Signed divide a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned divide a=100, b=7 -> lo=14, hi=2.
REQ-034 Divide a=0x00001234, b=0 -> hi=0x00001234, lo=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 start with alu_op=4'b0101 -> busy stays 0; start pulsed during CALC -> ignored and the original result is unchanged.
REQ-036 rst asserted 10 cycles into a divide -> busy=0 and hi=lo=0 with no clock edge, no done afterwards; back-to-back start in the done cycle -> second result 34 cycles later.
